// File: rtl/dispensador_troco_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dispensador_troco_if                                    |
// | Brief  : Coin-dispenser bus: start/balance in, coin handshake out|
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
interface dispensador_troco_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [5:0]       saldo;
    logic             vendeu;
    logic             refill;
    logic             next;
    logic [4:0]       moeda;
    logic             valid;
    logic             busy;
    logic             done;
    logic             erro;
    logic [5:0]       restante;
    logic [CNT_W-1:0] cnt20;
    logic [CNT_W-1:0] cnt10;
    logic [CNT_W-1:0] cnt5;

    modport master (
        output start, saldo, vendeu, refill, next,
        input  moeda, valid, busy, done, erro, restante, cnt20, cnt10, cnt5
    );

    modport slave (
        input  start, saldo, vendeu, refill, next,
        output moeda, valid, busy, done, erro, restante, cnt20, cnt10, cnt5
    );
endinterface
`default_nettype wire

// File: rtl/dispensador_troco.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dispensador_troco                                       |
// | Brief  : Greedy change dispenser with limited 20/10/5 coin stocks|
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module dispensador_troco #(
    parameter int PRICE    = 40,
    parameter int CNT_W    = 4,
    parameter int INIT_CNT = 4
) (
    input wire logic           clk,
    input wire logic           rst,
    dispensador_troco_if.slave bus
);
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SELECT = 3'd1;
    localparam logic [2:0] c_S_OFFER  = 3'd2;
    localparam logic [2:0] c_S_DONE   = 3'd3;
    localparam logic [2:0] c_S_ERROR  = 3'd4;

    localparam logic [5:0]       c_PRICE = 6'(PRICE);
    localparam logic [CNT_W-1:0] c_INIT  = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [4:0]       c_C20   = 5'd20;
    localparam logic [4:0]       c_C10   = 5'd10;
    localparam logic [4:0]       c_C5    = 5'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [5:0]       r_owed;
    logic [4:0]       r_coin;
    logic [4:0]       w_coin_sel;
    logic [5:0]       w_owed_start;
    logic [CNT_W-1:0] r_cnt20;
    logic [CNT_W-1:0] r_cnt10;
    logic [CNT_W-1:0] r_cnt5;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Largest coin that fits the debt and is still in stock; 0 means none.
    always_comb begin
        w_coin_sel = 5'd0;
        if (r_owed >= 6'd20 && r_cnt20 != '0) begin
            w_coin_sel = c_C20;
        end else if (r_owed >= 6'd10 && r_cnt10 != '0) begin
            w_coin_sel = c_C10;
        end else if (r_owed >= 6'd5 && r_cnt5 != '0) begin
            w_coin_sel = c_C5;
        end
    end

    // A sale whose balance does not cover the price is refunded in full.
    always_comb begin
        w_owed_start = bus.saldo;
        if (bus.vendeu && bus.saldo >= c_PRICE) begin
            w_owed_start = bus.saldo - c_PRICE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!bus.refill && bus.start) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_SELECT: begin
                if (r_owed == 6'd0) begin
                    w_state_nxt = c_S_DONE;
                end else if (w_coin_sel != 5'd0) begin
                    w_state_nxt = c_S_OFFER;
                end else begin
                    w_state_nxt = c_S_ERROR;
                end
            end
            c_S_OFFER: begin
                if (bus.next) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_DONE:  w_state_nxt = c_S_IDLE;
            c_S_ERROR: w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owed  <= 6'd0;
            r_coin  <= 5'd0;
            r_cnt20 <= c_INIT;
            r_cnt10 <= c_INIT;
            r_cnt5  <= c_INIT;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.refill) begin
                        r_cnt20 <= c_INIT;
                        r_cnt10 <= c_INIT;
                        r_cnt5  <= c_INIT;
                    end else if (bus.start) begin
                        r_owed <= w_owed_start;
                    end
                end
                c_S_SELECT: r_coin <= w_coin_sel;
                c_S_OFFER: begin
                    if (bus.next) begin
                        r_owed <= r_owed - {1'b0, r_coin};
                        case (r_coin)
                            c_C20:   r_cnt20 <= r_cnt20 - c_ONE;
                            c_C10:   r_cnt10 <= r_cnt10 - c_ONE;
                            c_C5:    r_cnt5  <= r_cnt5 - c_ONE;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.valid    = (r_state == c_S_OFFER);
        bus.moeda    = (r_state == c_S_OFFER) ? r_coin : 5'd0;
        bus.busy     = (r_state != c_S_IDLE);
        bus.done     = (r_state == c_S_DONE);
        bus.erro     = (r_state == c_S_ERROR);
        bus.restante = r_owed;
        bus.cnt20    = r_cnt20;
        bus.cnt10    = r_cnt10;
        bus.cnt5     = r_cnt5;
    end
endmodule
`default_nettype wire

// File: tb/tb_dispensador_troco.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_dispensador_troco                                    |
// | Brief  : Directed bench with greedy-payout model and scoreboard  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dispensador_troco;
    localparam int PRICE    = 40;
    localparam int CNT_W    = 4;
    localparam int INIT_CNT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispensador_troco_if #(.CNT_W(CNT_W)) bus ();

    dispensador_troco #(
        .PRICE    (PRICE),
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: stocks, debt and the coin sequence a greedy payout must produce.
    int den[3] = '{20, 10, 5};
    bit m_live = 1'b0;
    bit m_busy = 1'b0;
    int m_owed = 0;
    int m_s[3] = '{INIT_CNT, INIT_CNT, INIT_CNT};
    int q[$];
    int m_term = 0;
    int coin_log[$];
    int last_term = 0;
    int mc;
    int obs;

    function automatic void plan(input int owed);
        int o;
        int s[3];
        bit took;
        o = owed;
        s = m_s;
        q.delete();
        while (o > 0) begin
            took = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!took && o >= den[i] && s[i] > 0) begin
                    q.push_back(den[i]);
                    o -= den[i];
                    s[i]--;
                    took = 1'b1;
                end
            end
            if (!took) break;
        end
        m_term = (o == 0) ? 1 : 2;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("cnt20", 32'(bus.cnt20), m_s[0]);
            chk("cnt10", 32'(bus.cnt10), m_s[1]);
            chk("cnt5", 32'(bus.cnt5), m_s[2]);
            chk("restante", 32'(bus.restante), m_owed);
            chk("busy", 32'(bus.busy), 32'(m_busy));
            if (bus.valid) chk("moeda", 32'(bus.moeda), (q.size() > 0) ? q[0] : 0);
            else           chk("moeda_idle", 32'(bus.moeda), 0);
            obs = {bus.erro, bus.done};
            if (obs != 0) begin
                chk("terminal", obs, (m_busy && q.size() == 0) ? m_term : 0);
                last_term = obs;
            end
        end
        if (rst) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_owed = 0;
            m_s    = '{INIT_CNT, INIT_CNT, INIT_CNT};
            q.delete();
        end else if (m_live) begin
            if (!m_busy) begin
                if (bus.refill) begin
                    m_s = '{INIT_CNT, INIT_CNT, INIT_CNT};
                end else if (bus.start) begin
                    m_owed = (bus.vendeu && bus.saldo >= PRICE) ? int'(bus.saldo) - PRICE : int'(bus.saldo);
                    plan(m_owed);
                    m_busy = 1'b1;
                end
            end else begin
                if (bus.valid && bus.next && q.size() > 0) begin
                    mc = q.pop_front();
                    coin_log.push_back(int'(bus.moeda));
                    m_owed -= mc;
                    m_s[(mc == 20) ? 0 : ((mc == 10) ? 1 : 2)]--;
                end
                if (bus.done || bus.erro) m_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run(input logic [5:0] s, input logic v, output int cyc);
        coin_log.delete();
        last_term  = 0;
        bus.saldo  = s;
        bus.vendeu = v;
        bus.start  = 1'b1;
        cyc = 1;
        tick();
        bus.start = 1'b0;
        cyc++;
        while (!(bus.done || bus.erro) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("run_finished", 32'(bus.done || bus.erro), 1);
        tick();
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!bus.valid && k < 20) begin
            tick();
            k++;
        end
        chk("offer_seen", 32'(bus.valid), 1);
    endtask

    int cyc;

    initial begin
        bus.start  = 1'b0;
        bus.saldo  = 6'd0;
        bus.vendeu = 1'b0;
        bus.refill = 1'b0;
        bus.next   = 1'b0;
        do_reset();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cnt20", 32'(bus.cnt20), 4);

        // Sale of 45: single 5 refund
        bus.next = 1'b1;
        run(6'd45, 1'b1, cyc);
        chk("t1_latency", cyc, 5);
        chk("t1_ncoins", coin_log.size(), 1);
        chk("t1_coin", coin_log[0], 5);
        chk("t1_done", last_term, 1);
        chk("t1_cnt5", 32'(bus.cnt5), 3);

        // Cancel with 35: 20, 10, 5
        do_reset();
        bus.next = 1'b1;
        run(6'd35, 1'b0, cyc);
        chk("t2_ncoins", coin_log.size(), 3);
        chk("t2_coin0", coin_log[0], 20);
        chk("t2_coin1", coin_log[1], 10);
        chk("t2_coin2", coin_log[2], 5);
        chk("t2_cnt", {28'd0, bus.cnt20}*100 + {28'd0, bus.cnt10}*10 + {28'd0, bus.cnt5}, 333);

        // Owe 23: pays 20, then fails with 3 left
        run(6'd63, 1'b1, cyc);
        chk("t3_ncoins", coin_log.size(), 1);
        chk("t3_coin", coin_log[0], 20);
        chk("t3_erro", last_term, 2);
        chk("t3_restante", 32'(bus.restante), 3);

        // Drain the 20s, then fall back to 10s
        do_reset();
        bus.next = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            run(6'd60, 1'b1, cyc);
            if (r < 5) begin
                chk("t4_ncoins", coin_log.size(), 1);
                chk("t4_coin20", coin_log[0], 20);
            end else begin
                chk("t4_ncoins5", coin_log.size(), 2);
                chk("t4_coin10a", coin_log[0], 10);
                chk("t4_coin10b", coin_log[1], 10);
            end
        end
        chk("t4_cnt20", 32'(bus.cnt20), 0);
        chk("t4_cnt10", 32'(bus.cnt10), 2);

        // Stalled offer; start/refill pulses while busy must be ignored
        bus.next   = 1'b0;
        coin_log.delete();
        last_term  = 0;
        bus.saldo  = 6'd50;
        bus.vendeu = 1'b1;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid();
        for (int i = 0; i < 6; i++) begin
            bus.start  = (i == 1);
            bus.saldo  = (i == 1) ? 6'd63 : 6'd50;
            bus.refill = (i == 3);
            tick();
            chk("t5_valid", 32'(bus.valid), 1);
            chk("t5_moeda", 32'(bus.moeda), 10);
            chk("t5_restante", 32'(bus.restante), 10);
            chk("t5_cnt10", 32'(bus.cnt10), 2);
        end
        bus.start  = 1'b0;
        bus.refill = 1'b0;
        bus.next   = 1'b1;
        for (int k = 0; k < 20 && !bus.done && !bus.erro; k++) tick();
        chk("t5_done", 32'(bus.done), 1);
        tick();
        chk("t5_cnt10_after", 32'(bus.cnt10), 1);
        chk("t5_restante_after", 32'(bus.restante), 0);

        bus.refill = 1'b1;
        tick();
        bus.refill = 1'b0;
        chk("t4_refill", {28'd0, bus.cnt20}*100 + {28'd0, bus.cnt10}*10 + {28'd0, bus.cnt5}, 444);

        // Reset while a coin is on offer
        bus.next   = 1'b0;
        bus.saldo  = 6'd30;
        bus.vendeu = 1'b0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(bus.valid), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_restante", 32'(bus.restante), 0);
        chk("t6_cnt", {28'd0, bus.cnt20}*100 + {28'd0, bus.cnt10}*10 + {28'd0, bus.cnt5}, 444);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
